// File: rtl/zs_pkg.sv
// zs_pkg: shared FSM encoding and helpers for the zero-skip scanner.
package zs_pkg;

  typedef enum logic {
    ZS_IDLE = 1'b0,
    ZS_SCAN = 1'b1
  } zs_state_e;

  // Last address of a scan range, clipped to the top of the window.
  function automatic int unsigned range_hi(input int unsigned base,
                                           input int unsigned len,
                                           input int unsigned depth);
    if (len == 0) return base;
    if (base + len > depth) return depth - 1;
    return base + len - 1;
  endfunction

  // A shift command is legal for strides 1..max_stride.
  function automatic logic stride_ok(input int unsigned stride,
                                     input int unsigned max_stride);
    return (stride != 0) && (stride <= max_stride);
  endfunction

endpackage

// File: rtl/zs_next_nonzero.sv
// zs_next_nonzero: finds the lowest occupied non-zero entry in [lo, hi]
// and reports whether another one follows it inside the same range.
module zs_next_nonzero #(
  parameter int unsigned MEM_DEPTH  = 12,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic [MEM_DEPTH-1:0]  flags,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [CNT_WIDTH-1:0]  lo,
  input  logic [ADDR_WIDTH-1:0] hi,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  more_after
);

  // Priority scan from the bottom; entries at or above count are absent.
  always_comb begin
    found      = 1'b0;
    addr       = '0;
    more_after = 1'b0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      if ((CNT_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi) &&
          (CNT_WIDTH'(i) < count) && !flags[i]) begin
        if (found) begin
          more_after = 1'b1;
        end else begin
          found = 1'b1;
          addr  = ADDR_WIDTH'(i);
        end
      end
    end
  end

endmodule

// File: rtl/zero_skip_scanner.sv
// zero_skip_scanner: sliding window of is-zero flags plus a scan engine that
// streams addresses of non-zero entries over valid/ready.
// Optional: define ZS_SKIP_COUNT_EN to count range addresses skipped as zero.
module zero_skip_scanner
  import zs_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_STRIDE = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(MEM_DEPTH + 1),
  parameter int unsigned STRIDE_W   = $clog2(MAX_STRIDE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  shift,
  input  logic [STRIDE_W-1:0]   stride,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  input  logic                  scan_start,
  input  logic [ADDR_WIDTH-1:0] scan_base,
  input  logic [CNT_WIDTH-1:0]  scan_len,
  output logic                  scan_busy,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic [ADDR_WIDTH-1:0] idx_addr,
  output logic                  idx_last,
  output logic                  scan_done,
  output logic                  cmd_err,
  output logic [CNT_WIDTH-1:0]  skip_cnt
);

  zs_state_e             state, state_d;
  logic [MEM_DEPTH-1:0]  flags, flags_s, flags_d;
  logic [CNT_WIDTH-1:0]  count_d, cnt_s, shift_k, stride_c;
  logic                  shift_ok, wr_ok, busy, cmd_err_d;
  logic [ADDR_WIDTH-1:0] hi_q, hi_d, hi_start, search_hi;
  logic [CNT_WIDTH-1:0]  search_lo;
  logic                  search_empty;
  logic                  f_found, f_more, hit, accept;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  idx_valid_d, idx_last_d, scan_done_d;
  logic [ADDR_WIDTH-1:0] idx_addr_d;

  assign busy      = (state == ZS_SCAN);
  assign scan_busy = busy;

  // Window update: shift first, then append at the post-shift tail.
  always_comb begin
    stride_c = CNT_WIDTH'(stride);
    shift_ok = shift && stride_ok(32'(stride), MAX_STRIDE) && !busy;
    shift_k  = '0;
    if (shift_ok) shift_k = (stride_c < count) ? stride_c : count;
    flags_s  = flags >> shift_k;
    cnt_s    = count - shift_k;
    wr_ok    = w_en && (cnt_s != CNT_WIDTH'(MEM_DEPTH));
    flags_d  = flags_s;
    count_d  = cnt_s;
    if (wr_ok) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        if (CNT_WIDTH'(i) == cnt_s) flags_d[i] = (din == '0);
      end
      count_d = cnt_s + CNT_WIDTH'(1);
    end
    cmd_err_d = (w_en && !wr_ok) ||
                (shift && (!stride_ok(32'(stride), MAX_STRIDE) || busy)) ||
                (scan_start && busy);
  end

  // Window storage and occupancy status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags   <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      cmd_err <= 1'b0;
    end else begin
      flags   <= flags_d;
      count   <= count_d;
      full    <= (count_d == CNT_WIDTH'(MEM_DEPTH));
      empty   <= (count_d == '0);
      cmd_err <= cmd_err_d;
    end
  end

  assign hi_start = ADDR_WIDTH'(range_hi(32'(scan_base), 32'(scan_len), MEM_DEPTH));

  // Search window: a new range on start, or just past the accepted address.
  always_comb begin
    search_lo    = CNT_WIDTH'(idx_addr) + CNT_WIDTH'(1);
    search_hi    = hi_q;
    search_empty = 1'b0;
    if (!busy) begin
      search_lo    = CNT_WIDTH'(scan_base);
      search_hi    = hi_start;
      search_empty = (scan_len == '0);
    end
  end

  zs_next_nonzero #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_finder (
    .flags     (flags),
    .count     (count),
    .lo        (search_lo),
    .hi        (search_hi),
    .found     (f_found),
    .addr      (f_addr),
    .more_after(f_more)
  );

  assign hit    = f_found && !search_empty;
  assign accept = busy ? (idx_valid && idx_ready) : scan_start;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ZS_IDLE;
    else       state <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state;
    case (state)
      ZS_IDLE: if (scan_start && hit) state_d = ZS_SCAN;
      ZS_SCAN: if (idx_valid && idx_ready && !hit) state_d = ZS_IDLE;
      default: state_d = ZS_IDLE;
    endcase
  end

  // FSM outputs: load a new search result on start or handshake, else hold.
  always_comb begin
    idx_valid_d = idx_valid;
    idx_addr_d  = idx_addr;
    idx_last_d  = idx_last;
    scan_done_d = 1'b0;
    hi_d        = hi_q;
    if (accept) begin
      idx_valid_d = hit;
      idx_addr_d  = hit ? f_addr : '0;
      idx_last_d  = hit && !f_more;
      scan_done_d = !hit;
      hi_d        = search_hi;
    end
  end

  // Registered scan outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_valid <= 1'b0;
      idx_addr  <= '0;
      idx_last  <= 1'b0;
      scan_done <= 1'b0;
      hi_q      <= '0;
    end else begin
      idx_valid <= idx_valid_d;
      idx_addr  <= idx_addr_d;
      idx_last  <= idx_last_d;
      scan_done <= scan_done_d;
      hi_q      <= hi_d;
    end
  end

`ifdef ZS_SKIP_COUNT_EN
  localparam int unsigned SUM_W = CNT_WIDTH + 1;
  logic [CNT_WIDTH-1:0] skip_inc, skip_base, skip_d;
  logic [SUM_W-1:0]     skip_sum;

  // Addresses passed over by this search step, saturating accumulation.
  always_comb begin
    skip_inc = '0;
    if (!search_empty) begin
      if (hit)
        skip_inc = CNT_WIDTH'(f_addr) - search_lo;
      else if (search_lo <= CNT_WIDTH'(search_hi))
        skip_inc = CNT_WIDTH'(search_hi) + CNT_WIDTH'(1) - search_lo;
    end
    skip_base = busy ? skip_cnt : '0;
    skip_sum  = SUM_W'(skip_base) + SUM_W'(skip_inc);
    skip_d    = skip_cnt;
    if (accept) begin
      skip_d = (skip_sum > SUM_W'(MEM_DEPTH)) ? CNT_WIDTH'(MEM_DEPTH)
                                               : CNT_WIDTH'(skip_sum);
    end
  end

  // Skip counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) skip_cnt <= '0;
    else       skip_cnt <= skip_d;
  end
`else
  assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_zero_skip_scanner.sv
// Testbench for zero_skip_scanner: queue-based window model, scoreboard of
// expected scan outputs, and a negedge monitor that pops on each handshake.
module tb_zero_skip_scanner;

  localparam int MEM_DEPTH  = 12;
  localparam int MAX_STRIDE = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          shift = 1'b0;
  logic [SW-1:0] stride = '0;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          scan_start = 1'b0;
  logic [AW-1:0] scan_base = '0;
  logic [CW-1:0] scan_len = '0;
  logic          scan_busy, idx_valid;
  logic          idx_ready = 1'b0;
  logic [AW-1:0] idx_addr;
  logic          idx_last, scan_done, cmd_err;
  logic [CW-1:0] skip_cnt;

  zero_skip_scanner dut (
    .clk(clk), .reset(reset), .w_en(w_en), .din(din), .shift(shift),
    .stride(stride), .count(count), .full(full), .empty(empty),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_busy(scan_busy), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_addr(idx_addr), .idx_last(idx_last), .scan_done(scan_done),
    .cmd_err(cmd_err), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int addr;
    bit last;
    int skip;
  } exp_t;

  exp_t sb[$];
  int   mdl[$];
  int   n_checks = 0;
  int   n_err = 0;
  exp_t mon_e;
  bit   prev_stall = 1'b0;
  int   prev_addr = 0;
  bit   prev_last = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Monitor: stability under stall, and scoreboard pops on handshake/done.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall && idx_valid) begin
        chk("stall_addr", int'(idx_addr), prev_addr);
        chk("stall_last", int'(idx_last), int'(prev_last));
      end
      if (idx_valid && idx_ready) begin
        if (sb.size() == 0) fail_now("unexpected_idx");
        else begin
          mon_e = sb.pop_front();
          chk("idx_kind", int'(mon_e.done), 0);
          chk("idx_addr", int'(idx_addr), mon_e.addr);
          chk("idx_last", int'(idx_last), int'(mon_e.last));
        end
      end
      if (scan_done) begin
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          mon_e = sb.pop_front();
          chk("done_kind", int'(mon_e.done), 1);
`ifdef ZS_SKIP_COUNT_EN
          chk("skip_cnt", int'(skip_cnt), mon_e.skip);
`else
          chk("skip_cnt", int'(skip_cnt), 0);
`endif
        end
      end
      prev_stall = idx_valid && !idx_ready;
      prev_addr  = int'(idx_addr);
      prev_last  = idx_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Single write/shift command against the window model.
  task automatic op(input bit w, input int d, input bit sh, input int st);
    int k;
    bit e_err;
    e_err = 1'b0;
    k = 0;
    if (sh) begin
      if (st < 1 || st > MAX_STRIDE) e_err = 1'b1;
      else k = (st < mdl.size()) ? st : mdl.size();
    end
    repeat (k) void'(mdl.pop_front());
    if (w) begin
      if (mdl.size() == MEM_DEPTH) e_err = 1'b1;
      else mdl.push_back(d);
    end
    w_en = w; din = DW'(d); shift = sh; stride = SW'(st);
    @(posedge clk); #1;
    w_en = 1'b0; shift = 1'b0;
    @(negedge clk);
    chk("count", int'(count), mdl.size());
    chk("full", int'(full), int'(mdl.size() == MEM_DEPTH));
    chk("empty", int'(empty), int'(mdl.size() == 0));
    chk("cmd_err", int'(cmd_err), int'(e_err));
  endtask

  // Scan: model pushes expected addresses; mode 0 ready=1, 1 random, 2 low 3 cycles.
  task automatic run_scan(input int base, input int len, input int mode, input bit inject);
    int lo, hi, n, sz, cyc;
    bit done_seen;
    exp_t e;
    lo = base;
    hi = base + len - 1;
    if (hi > MEM_DEPTH - 1) hi = MEM_DEPTH - 1;
    n = 0; sz = 0;
    if (len > 0 && lo <= hi) begin
      sz = hi - lo + 1;
      for (int a = lo; a <= hi; a++) begin
        if (a < mdl.size() && mdl[a] != 0) begin
          e.done = 1'b0; e.addr = a; e.last = 1'b0; e.skip = 0;
          sb.push_back(e);
          n++;
        end
      end
    end
    if (n > 0) begin
      e = sb.pop_back();
      e.last = 1'b1;
      sb.push_back(e);
    end
    e.done = 1'b1; e.addr = 0; e.last = 1'b0; e.skip = sz - n;
    sb.push_back(e);
    @(posedge clk); #1;
    scan_start = 1'b1; scan_base = AW'(base); scan_len = CW'(len); idx_ready = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 200) begin
      case (mode)
        0:       idx_ready = 1'b1;
        1:       idx_ready = 1'($urandom_range(0, 1));
        default: idx_ready = (cyc >= 3);
      endcase
      if (inject && cyc == 1) begin
        shift = 1'b1; stride = SW'(1);
        scan_start = 1'b1; scan_base = '0; scan_len = CW'(12);
      end
      @(negedge clk);
      if (mode == 0 && cyc == 0) chk("busy_first", int'(scan_busy), int'(n > 0));
      if (inject && cyc == 2) begin
        chk("err_in_scan", int'(cmd_err), 1);
        chk("count_in_scan", int'(count), mdl.size());
      end
      if (scan_done) begin
        done_seen = 1'b1;
        if (mode == 0) chk("done_latency", cyc, n);
      end
      @(posedge clk); #1;
      shift = 1'b0; scan_start = 1'b0;
      cyc++;
    end
    idx_ready = 1'b0;
    if (!done_seen) fail_now("scan_timeout");
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int d, st;
    #1 reset = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_busy", int'(scan_busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic stream
    op(1, 3, 0, 0); op(1, 0, 0, 0); op(1, 5, 0, 0);
    op(1, 0, 0, 0); op(1, 0, 0, 0); op(1, 7, 0, 0);
    run_scan(0, 6, 0, 0);

    // Shift by 2 with simultaneous write of 9
    op(1, 9, 1, 2);
    run_scan(0, 12, 0, 0);

    // Drain, fill with zeros, overflow
    op(0, 0, 1, 4); op(0, 0, 1, 4);
    for (int i = 0; i < MEM_DEPTH; i++) op(1, 0, 0, 0);
    op(1, 0, 0, 0);
    op(0, 0, 1, 0);
    op(0, 0, 1, 5);
    run_scan(4, 4, 0, 0);
    run_scan(3, 0, 0, 0);

    // Stall with illegal shift/scan_start during the scan
    op(0, 0, 1, 4);
    op(1, 1, 0, 0); op(1, 2, 0, 0); op(1, 3, 0, 0); op(1, 4, 0, 0);
    run_scan(0, 12, 2, 1);

    // Random mix
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_scan($urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
      end else begin
        d  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 65535);
        st = $urandom_range(0, 7);
        op(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), st);
      end
    end

    // Reset in the middle of a stalled scan
    op(0, 0, 1, 4); op(0, 0, 1, 4); op(0, 0, 1, 4);
    op(1, 5, 0, 0); op(1, 6, 0, 0);
    @(posedge clk); #1;
    scan_start = 1'b1; scan_base = '0; scan_len = CW'(12); idx_ready = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b0;
    @(posedge clk); #1;
    chk("busy_pre_reset", int'(scan_busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(idx_valid), 0);
    chk("mid_rst_addr", int'(idx_addr), 0);
    chk("mid_rst_last", int'(idx_last), 0);
    chk("mid_rst_busy", int'(scan_busy), 0);
    chk("mid_rst_done", int'(scan_done), 0);
    chk("mid_rst_err", int'(cmd_err), 0);
    chk("mid_rst_skip", int'(skip_cnt), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    mdl.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_done", int'(scan_done), 0);
    end
    run_scan(0, 12, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zero_skip_scanner.md
Name: zero_skip_scanner

Overview:
- Successor to the per-PE zero-flag buffer.
- Holds one "is-zero" flag per scratchpad entry in a sliding window, fed by write and strided shift.
- Adds a scan engine that streams the addresses of non-zero entries within a requested range over a valid/ready handshake, so the MAC skips zero operands without idle cycles.
- Sits beside the ifmap/filter scratchpads inside the processing element.

Parameters:
- MEM_DEPTH, 12: number of window entries.
- DATA_WIDTH, 16: width of written data.
- MAX_STRIDE, 4: largest shift amount per shift command.
- ADDR_WIDTH, $clog2(MEM_DEPTH): entry address width.
- CNT_WIDTH, $clog2(MEM_DEPTH+1): occupancy/count width.
- STRIDE_W, $clog2(MAX_STRIDE+1): stride field width.

Ports:
- clk, in, 1: clock; all state changes on rising edge.
- reset, in, 1: asynchronous, active-high.
- w_en, in, 1: append din's zero flag at tail.
- din, in, DATA_WIDTH: data; flag = (din == 0).
- shift, in, 1: slide window down by stride.
- stride, in, STRIDE_W: shift amount, legal 1..MAX_STRIDE.
- count, out, CNT_WIDTH: occupied entries.
- full, out, 1: count == MEM_DEPTH.
- empty, out, 1: count == 0.
- scan_start, in, 1: request scan (accepted only when idle).
- scan_base, in, ADDR_WIDTH: first address of scan range.
- scan_len, in, CNT_WIDTH: number of addresses in range.
- scan_busy, out, 1: scan in progress.
- idx_valid, out, 1: idx_addr holds a non-zero entry address.
- idx_ready, in, 1: consumer accepts idx_addr.
- idx_addr, out, ADDR_WIDTH: next non-zero address.
- idx_last, out, 1: no further non-zero entry in range after idx_addr.
- scan_done, out, 1: one-cycle pulse at scan end.
- cmd_err, out, 1: one-cycle pulse on an illegal command.
- skip_cnt, out, CNT_WIDTH: see Optional Feature.

Behaviour:
- Reset:
  - All flags = 0 and count = 0; full = 0, empty = 1.
  - FSM returns to IDLE; idx_valid, idx_addr, idx_last, scan_busy, scan_done, cmd_err and skip_cnt all = 0.
  - Reset mid-scan aborts the scan silently, with no scan_done.
- Write:
  - flag[count] <= (din == 0); count + 1.
  - Write when full is dropped, and cmd_err pulses.
- Shift:
  - k = min(stride, count); flag[i] <= flag[i+k]; top k entries cleared; count - k.
  - stride == 0 or > MAX_STRIDE: ignored, cmd_err pulses.
  - Shift while scan_busy: ignored, cmd_err pulses.
- Shift and write in the same cycle: shift applies first; the write lands at the new tail (count - k); count = count - k + 1.
- Entries at addresses >= count are treated as zero/absent and are never emitted.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on scan_start. Latch lo = scan_base and hi = scan_base + scan_len - 1, saturated to MEM_DEPTH-1. Set the cursor to the first non-zero address >= lo.
  - scan_start while busy: ignored, cmd_err pulses.
  - In SCAN, idx_valid = 1 whenever a non-zero address exists in [cursor, hi].
  - On idx_valid & idx_ready: cursor advances to the next non-zero address after idx_addr.
  - If no non-zero address remains: idx_valid drops, scan_done pulses, FSM -> IDLE.
- Latency:
  - First idx_valid appears in the cycle after scan_start.
  - With idx_ready held high, the block emits one address per cycle.
  - scan_done is asserted in the cycle after the handshake on the idx_last entry.
  - With scan_len == 0 or an all-zero range, scan_done is asserted in the cycle after scan_start and idx_valid never rises.
- Handshake rules:
  - idx_addr and idx_last are held stable while idx_valid & !idx_ready.
  - A write during a scan is permitted. A newly appended non-zero flag inside [cursor+1, hi] is picked up at the next advance.

Optional Feature:
- Macro: ZS_SKIP_COUNT_EN.
- Defined:
  - skip_cnt counts range addresses skipped as zero during the current scan.
  - Cleared on an accepted scan_start; holds its final value after scan_done.
  - Saturates at MEM_DEPTH.
- Undefined: skip_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package zs_pkg:
  - FSM state encoding (ZS_IDLE, ZS_SCAN).
  - Helper functions: range saturation, stride legality check.
- One sub-module, zs_next_nonzero: combinational priority finder.
  - Inputs: flags, count, lower bound, upper bound.
  - Outputs: found, addr, more_after.
  - Instantiated for the cursor search.

Test Plan:
- Write 3, 0, 5, 0, 0, 7 then scan base 0 len 6 with ready = 1 -> idx_addr 0, 2, 5 on consecutive cycles; idx_last on 5; scan_done next cycle; skip_cnt = 3 (macro on).
- 12 writes, then a 13th -> full = 1 and cmd_err pulse; count stays 12.
- count 6, shift stride 2 with a simultaneous write of 9 -> count = 5; flags moved down 2; flag[4] = 0 (the non-zero 9).
- Scan base 4 len 4 over all-zero flags -> no idx_valid; scan_done the cycle after start.
- Scan with ready low for 3 cycles -> idx_addr/idx_last stable; shift and scan_start during the scan -> cmd_err pulses, state unchanged.
- Reset asserted mid-scan -> all outputs 0, empty = 1, no scan_done; new scan after reset emits nothing.
